// File: rtl/hex_7_segment_capture_if.sv
// Display-bus bundle between a hex 7-segment driver (master) and the capture monitor (slave).
// The master drives the multiplexed segment/anode bus and observes the reassembled result.
interface hex_7_segment_capture_if;
  logic [6:0]  a_to_g;      // active-low segments, bit6=a .. bit0=g
  logic [3:0]  an;          // active-high one-hot digit enables
  logic [15:0] x;           // last complete reassembled word
  logic        x_valid;     // one-clock pulse when x is refreshed
  logic        decode_err;  // one-clock pulse on a stable, non-hex pattern
  logic [3:0]  frame_seen;  // digits captured so far in the current frame

  modport master (
    output a_to_g, an,
    input  x, x_valid, decode_err, frame_seen
  );

  modport slave (
    input  a_to_g, an,
    output x, x_valid, decode_err, frame_seen
  );
endinterface

// File: rtl/hex_7_segment_capture.sv
// Receive side of the hex 7-segment display path: waits for each multiplexed digit to
// dwell stably for SETTLE samples, decodes its glyph back to a nibble and reassembles
// the 16-bit word once all four digits of a frame have been captured.
module hex_7_segment_capture #(
  parameter int SETTLE = 16,  // identical consecutive samples needed for a capture (>= 2)
  parameter int CNT_W  = 5    // dwell counter width, 2**CNT_W > SETTLE
) (
  input  logic                    clk,
  input  logic                    clr,
  hex_7_segment_capture_if.slave  bus
);

  typedef enum logic [1:0] {
    BLANK    = 2'd0,  // no single digit enabled
    SETTLING = 2'd1,  // one digit enabled, waiting for the pattern to dwell
    HELD     = 2'd2   // digit captured for this dwell, waiting for a change
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);

  // Input stage and the previous registered sample used for change detection.
  logic [6:0]       a_r, a_q;
  logic [3:0]       an_r, an_q;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic             same, one_hot;
  logic             capture, cap_ok, cap_bad;
  logic             glyph_ok;
  logic [3:0]       nibble;
  logic [1:0]       idx;

  logic [15:0]      slots;
  logic [15:0]      x_q;
  logic [3:0]       seen;
  logic             x_valid_q, err_q;

  // Maps an active-low segment pattern to {valid, nibble}.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b0_0000;
    case (seg)
      7'b0000001: r = {1'b1, 4'h0};
      7'b1001111: r = {1'b1, 4'h1};
      7'b0010010: r = {1'b1, 4'h2};
      7'b0000110: r = {1'b1, 4'h3};
      7'b1001100: r = {1'b1, 4'h4};
      7'b0100100: r = {1'b1, 4'h5};
      7'b0100000: r = {1'b1, 4'h6};
      7'b0001111: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0000100: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b1100000: r = {1'b1, 4'hB};
      7'b0110001: r = {1'b1, 4'hC};
      7'b1000010: r = {1'b1, 4'hD};
      7'b0110000: r = {1'b1, 4'hE};
      7'b0111000: r = {1'b1, 4'hF};
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Register the raw bus once and keep the prior registered sample for comparison.
  // NOTE: every clocked assignment is non-blocking so each stage sees last-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      a_r  <= 7'h7F;
      an_r <= 4'h0;
      a_q  <= 7'h7F;
      an_q <= 4'h0;
    end else begin
      a_r  <= bus.a_to_g;
      an_r <= bus.an;
      a_q  <= a_r;
      an_q <= an_r;
    end
  end

  assign same    = (an_r == an_q) && (a_r == a_q);
  assign one_hot = $onehot(an_r);

  // FSM state and dwell counter register.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= BLANK;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state and dwell-count logic; the counter stops at SETTLE while HELD.
  // NOTE: defaults first so no path through this block leaves a latch behind.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (!one_hot) begin
      state_nx = BLANK;
      cnt_nx   = '0;
    end else begin
      case (state)
        BLANK: begin
          state_nx = SETTLING;
          cnt_nx   = CNT_W'(1);
        end
        SETTLING: begin
          if (same) begin
            cnt_nx = cnt + CNT_W'(1);
            if (cnt_nx == SETTLE_C) state_nx = HELD;
          end else begin
            cnt_nx = CNT_W'(1);
          end
        end
        HELD: begin
          if (!same) begin
            state_nx = SETTLING;
            cnt_nx   = CNT_W'(1);
          end
        end
        default: begin
          state_nx = BLANK;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Capture strobes: a dwell completes exactly on the SETTLING->HELD transition.
  always_comb begin
    capture            = (state == SETTLING) && (state_nx == HELD);
    {glyph_ok, nibble} = decode_glyph(a_r);
    cap_ok             = capture && glyph_ok;
    cap_bad            = capture && !glyph_ok;
    case (an_r)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  // Slot storage, frame tracking and word assembly.
  always_ff @(posedge clk) begin
    if (clr) begin
      slots     <= '0;
      seen      <= '0;
      x_q       <= '0;
      x_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      x_valid_q <= 1'b0;
      err_q     <= cap_bad;
      if (seen == 4'hF) begin
        // Publish the completed frame; a capture on this edge opens the next one.
        x_q       <= slots;
        x_valid_q <= 1'b1;
        seen      <= cap_ok ? an_r : 4'h0;
      end else if (cap_ok) begin
        seen <= seen | an_r;
      end
      if (cap_ok) slots[{idx, 2'b00} +: 4] <= nibble;
    end
  end

  assign bus.x          = x_q;
  assign bus.x_valid    = x_valid_q;
  assign bus.decode_err = err_q;
  assign bus.frame_seen = seen;

endmodule

// File: tb/tb_hex_7_segment_capture.sv
// Bench for hex_7_segment_capture: directed display scans plus random dwells, every
// cycle compared against a run-length reference model of the capture rules.
module tb_hex_7_segment_capture;

  localparam int SETTLE = 16;

  // Active-low glyphs for nibbles 0..F.
  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic clk;
  logic clr;

  hex_7_segment_capture_if bus ();

  hex_7_segment_capture #(.SETTLE(SETTLE), .CNT_W(5)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [3:0]  m_slot [4];
  logic [3:0]  m_seen;
  logic [15:0] m_x;
  logic        m_xv, m_err;
  logic [10:0] m_prev;
  int          m_run;

  // Event counters for frame-level checks.
  int n_xv, n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reverse glyph lookup by searching the table.
  task automatic lookup(input logic [6:0] seg, output logic ok, output logic [3:0] nib);
    ok  = 1'b0;
    nib = 4'h0;
    for (int k = 0; k < 16; k++)
      if (GLYPH[k] == seg) begin
        ok  = 1'b1;
        nib = 4'(k);
      end
  endtask

  // Applies the capture rules for one rising edge, given what the pins and clr showed there.
  task automatic model_edge();
    logic       ok;
    logic [3:0] nib;
    m_xv  = 1'b0;
    m_err = 1'b0;
    if (clr) begin
      for (int k = 0; k < 4; k++) m_slot[k] = 4'h0;
      m_seen = 4'h0;
      m_x    = 16'h0;
      m_run  = 0;
      m_prev = '0;
    end else begin
      if (m_seen == 4'hF) begin
        m_x    = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
        m_xv   = 1'b1;
        m_seen = 4'h0;
      end
      // A run that reached exactly SETTLE samples by the previous edge is captured now.
      if (m_run == SETTLE) begin
        lookup(m_prev[6:0], ok, nib);
        if (ok) begin
          for (int k = 0; k < 4; k++)
            if (m_prev[7+k]) m_slot[k] = nib;
          m_seen = m_seen | m_prev[10:7];
        end else begin
          m_err = 1'b1;
        end
      end
      if ($onehot(bus.an) && m_run > 0 && {bus.an, bus.a_to_g} == m_prev) m_run++;
      else if ($onehot(bus.an)) m_run = 1;
      else m_run = 0;
      m_prev = {bus.an, bus.a_to_g};
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge and compare just after it.
  task automatic step(input logic c, input logic [3:0] a_n, input logic [6:0] seg);
    @(negedge clk);
    clr        = c;
    bus.an     = a_n;
    bus.a_to_g = seg;
    @(posedge clk);
    model_edge();
    #1;
    check("x", 32'(bus.x), 32'(m_x));
    check("x_valid", 32'(bus.x_valid), 32'(m_xv));
    check("decode_err", 32'(bus.decode_err), 32'(m_err));
    check("frame_seen", 32'(bus.frame_seen), 32'(m_seen));
    if (bus.x_valid === 1'b1) n_xv++;
    if (bus.decode_err === 1'b1) n_err++;
  endtask

  task automatic dwell(input logic [3:0] a_n, input logic [6:0] seg, input int n);
    for (int k = 0; k < n; k++) step(1'b0, a_n, seg);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 4'h0, 7'h7F);
  endtask

  task automatic scan(input logic [15:0] w, input int len, input bit rev);
    int d;
    for (int k = 0; k < 4; k++) begin
      d = rev ? 3 - k : k;
      dwell(4'(1 << d), GLYPH[w[4*d +: 4]], len);
    end
  endtask

  initial begin
    logic [3:0] a_n;
    logic [6:0] seg;
    int         pick;

    clr        = 1'b1;
    bus.an     = 4'h0;
    bus.a_to_g = 7'h7F;

    // Reset state.
    do_reset(3);
    check("reset_x", 32'(bus.x), 32'h0);
    check("reset_frame_seen", 32'(bus.frame_seen), 32'h0);

    // 1: driver-like scans of A5C3, two full frames.
    n_xv = 0; n_err = 0;
    scan(16'hA5C3, 64, 1'b0);
    scan(16'hA5C3, 64, 1'b0);
    check("scan_x", 32'(bus.x), 32'hA5C3);
    check("scan_xvalid_count", 32'(n_xv), 32'd2);
    check("scan_err_count", 32'(n_err), 32'd0);

    // 2: dwells shorter than SETTLE never capture.
    do_reset(1);
    n_xv = 0;
    for (int r = 0; r < 3; r++) scan(16'h1357, 10, 1'b0);
    check("short_frame_seen", 32'(bus.frame_seen), 32'h0);
    check("short_xvalid_count", 32'(n_xv), 32'd0);

    // 3: blank glyph on digit 0 gives exactly one decode_err.
    do_reset(1);
    n_err = 0;
    dwell(4'b0001, 7'b1111111, 30);
    check("bad_glyph_err_count", 32'(n_err), 32'd1);
    check("bad_glyph_frame_seen", 32'(bus.frame_seen), 32'h0);

    // 4: non-one-hot enables never capture.
    n_err = 0; n_xv = 0;
    dwell(4'b0011, GLYPH[4'h2], 100);
    dwell(4'b0000, GLYPH[4'h3], 100);
    check("blank_frame_seen", 32'(bus.frame_seen), 32'h0);
    check("blank_events", 32'(n_err + n_xv), 32'd0);

    // 5: partial frame of 1234 discarded by clr, then a clean BEEF frame.
    dwell(4'b0001, GLYPH[4'h4], 20);
    dwell(4'b0010, GLYPH[4'h3], 20);
    check("partial_frame_seen", 32'(bus.frame_seen), 32'h3);
    do_reset(1);
    check("clr_frame_seen", 32'(bus.frame_seen), 32'h0);
    n_xv = 0;
    scan(16'hBEEF, 64, 1'b0);
    check("beef_x", 32'(bus.x), 32'hBEEF);
    check("beef_xvalid_count", 32'(n_xv), 32'd1);

    // 6: reverse-order scan of 0F0F with digit 2 re-captured as 7 before digit 0.
    do_reset(1);
    dwell(4'b1000, GLYPH[4'h0], 40);
    dwell(4'b0100, GLYPH[4'hF], 40);
    dwell(4'b0010, GLYPH[4'h0], 40);
    dwell(4'b0100, GLYPH[4'h7], 40);
    dwell(4'b0001, GLYPH[4'hF], 40);
    dwell(4'b0000, 7'h7F, 4);
    check("latest_wins_x", 32'(bus.x), 32'h070F);

    // 7: random dwells, glyphs, junk patterns, blanking and resets.
    for (int r = 0; r < 150; r++) begin
      pick = int'($urandom_range(0, 99));
      a_n  = 4'(1 << $urandom_range(0, 3));
      seg  = GLYPH[$urandom_range(0, 15)];
      if (pick < 3) begin
        do_reset(int'($urandom_range(1, 2)));
      end else if (pick < 10) begin
        dwell(4'($urandom_range(0, 15)), seg, int'($urandom_range(1, 30)));
      end else begin
        if (pick < 18) seg = 7'($urandom_range(0, 127));
        dwell(a_n, seg, int'($urandom_range(3, 40)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
